seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Multi-digit seven-segment display controller fed by the UART receiver's byte stream (byte + one-cycle valid strobe).
- Parses ASCII commands into a staging buffer and commits it to a display buffer on carriage return.
- Time-multiplexes the committed digits onto a shared segment bus with one-hot digit enables and a ghosting-suppression blank interval.
- Sits between the UART receiver and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 12000, clock cycles per digit slot (1 ms at 12 MHz); must be greater than BLANK_CYCLES+1.
- BLANK_CYCLES, 48, cycles at the start of each slot with all enables and segments off.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- rx_byte  input  8  received byte, valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe, at most one byte per cycle.
- seg  output  7  segments {a,b,c,d,e,f,g}, bit6=a, active-high, registered.
- an  output  NUM_DIGITS  one-hot digit enable, active-high, registered; an[0] is the rightmost digit.
- cmd_err  output  1  one-cycle pulse on an unrecognised byte, registered.

Behaviour:
- Reset (async, resetn=0): all staging and display codes = BLANK (4'hF); seg=0; an=0; cmd_err=0; scan index=0; FSM=BLANK; slot counter=0.
- Digit code is 4 bits: 0..9 are numerals, and 4'hF is blank. Decode (a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - blank and codes 10..14 decode to 0000000.
- Byte parsing, applied on the cycle rx_valid=1; the effect is visible in the registers the next cycle:
  - 0x30..0x39: staging shifts left (stg[k] <= stg[k-1]), stg[0] <= byte-0x30, old stg[NUM_DIGITS-1] is discarded.
  - 0x08 (backspace): staging shifts right, stg[NUM_DIGITS-1] <= BLANK.
  - 'C' (0x43) or 'c' (0x63): all staging <= BLANK; display unchanged.
  - 0x0D (CR): display <= staging, then all staging <= BLANK, in the same cycle.
  - 0x0A (LF): ignored, no error.
  - Any other byte: no buffer change; cmd_err=1 for exactly one cycle.
- Scan FSM: two states, BLANK and DRIVE.
  - BLANK: an=0, seg=0 for BLANK_CYCLES cycles, then go to DRIVE.
  - On DRIVE entry: latch lat <= display[idx]. Hold an = one-hot(idx) and seg = decode(lat) for SCAN_DIV-BLANK_CYCLES cycles.
  - DRIVE exit: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1; go to BLANK.
  - Full frame = NUM_DIGITS*SCAN_DIV cycles. an is never multi-hot and never changes without a preceding blank interval.
- A commit mid-DRIVE does not alter the digit currently lit. New values appear at the next DRIVE entry for each index.
- Parsing and scanning are independent; rx_valid is accepted in every FSM state, with no back-pressure.
- Reset asserted mid-slot forces all outputs to 0 immediately, asynchronously. After deassertion, scanning restarts at idx=0 in BLANK.

Test Plan:
(Benches use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.)
- Reset release, no bytes: an=0 for 2 cycles, then 0001 for 6 cycles, 0000 for 2 cycles, then 0010 for 6 cycles, and so on; seg=0000000 throughout.
- Send "1","2","3","4",CR: display = {1,2,3,4}. Next frame: an=0001 with seg=0110011 ('4'); an=1000 with seg=0110000 ('1').
- Send "5","6","7","8","9",CR: digit '5' is discarded. an=1000 shows 1011111 ('6'); an=0001 shows 1111011 ('9').
- Send "1","2",0x08,CR: display = {B,B,B,1}. Only an=0001 lights, with 0110000; the other slots show seg=0.
- Send "7" then 'c' then CR: display becomes all blank. Send 'x' (0x78): cmd_err high exactly one cycle and buffers unchanged. Send 0x0A: no cmd_err.
- CR committing {8,8,8,8} mid-DRIVE of idx=1 (previous display 0): the current slot keeps 1111110 until its blank interval; idx=2 shows 1111111. Pulsing resetn low mid-DRIVE forces an=0, seg=0 the same cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: parses UART digit commands into a staging
// buffer, commits on CR, and time-multiplexes digits with blank intervals.
// Ports: clk, resetn (async, active-low), rx_byte/rx_valid (byte stream in),
//        seg {a..g} and one-hot an (registered), cmd_err (one-cycle pulse).
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 12000,
    parameter int BLANK_CYCLES = 48
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  cmd_err
);

    localparam int CW = $clog2(SCAN_DIV + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRV_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    localparam logic [NUM_DIGITS-1:0][3:0] ALL_BLANK = {NUM_DIGITS{4'hF}};

    logic [NUM_DIGITS-1:0][3:0] stg_q, stg_d;
    logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
    logic                       cmd_err_q, cmd_err_d;
    logic [0:0]                 state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [3:0]                 lat_q, lat_d;
    logic [6:0]                 seg_q, seg_d;
    logic [NUM_DIGITS-1:0]      an_q, an_d;

    logic is_digit;
    logic is_bs;
    logic is_clr;
    logic is_cr;
    logic is_lf;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign is_bs    = (rx_byte == 8'h08);
    assign is_clr   = (rx_byte == 8'h43) || (rx_byte == 8'h63);
    assign is_cr    = (rx_byte == 8'h0D);
    assign is_lf    = (rx_byte == 8'h0A);

    // Command parser
    always_comb begin
        stg_d     = stg_q;
        disp_d    = disp_q;
        cmd_err_d = 1'b0;
        if (rx_valid) begin
            unique case (1'b1)
                is_digit: stg_d = {stg_q[NUM_DIGITS-2:0], rx_byte[3:0]};
                is_bs:    stg_d = {4'hF, stg_q[NUM_DIGITS-1:1]};
                is_clr:   stg_d = ALL_BLANK;
                is_cr: begin
                    disp_d = stg_q;
                    stg_d  = ALL_BLANK;
                end
                is_lf:    stg_d = stg_q;
                default:  cmd_err_d = 1'b1;
            endcase
        end
    end

    // Scan FSM; the digit code is latched at DRIVE entry so a commit
    // never changes the digit currently lit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        lat_d   = lat_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    lat_d   = disp_q[idx_q];
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRV_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state so they line up with state_q.
    always_comb begin
        an_d  = '0;
        seg_d = '0;
        if (state_d == ST_DRIVE) begin
            an_d  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_d;
            seg_d = decode(lat_d);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stg_q     <= ALL_BLANK;
            disp_q    <= ALL_BLANK;
            cmd_err_q <= 1'b0;
            state_q   <= ST_BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            lat_q     <= 4'hF;
            seg_q     <= '0;
            an_q      <= '0;
        end else begin
            stg_q     <= stg_d;
            disp_q    <= disp_d;
            cmd_err_q <= cmd_err_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign cmd_err = cmd_err_q;

endmodule
